// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer slice.
//   - seq_state_t : FSM state encoding, visible on the state port
//                   (IDLE=0, RUN=1, PAUSE=2, DONE=3).
//   - DEFAULT_WIDTH / DEFAULT_PRESCALE_W : default datapath and prescaler widths.
package counter_seq_pkg;

    localparam int DEFAULT_WIDTH      = 7;
    localparam int DEFAULT_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit up-counter datapath driven by counter_sequencer.
// Ports:
//   clk       in  rising-edge clock
//   clear     in  synchronous clear (highest priority)
//   load      in  load q from load_val
//   inc       in  increment q (wraps modulo 2^WIDTH)
//   load_val  in  preload value
//   limit_r   in  frozen terminal count from the sequencer
//   q         out registered count
//   at_limit  out combinational q == limit_r
module counter_core
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit_r,
    output logic [WIDTH-1:0] q,
    output logic             at_limit
);

    logic [WIDTH-1:0] q_r;

    // Count register: clear > load > increment.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_r <= {WIDTH{1'b0}};
        end else if (load) begin
            q_r <= load_val;
        end else if (inc) begin
            q_r <= q_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

    assign q        = q_r;
    assign at_limit = (q_r == limit_r);

endmodule

// File: rtl/counter_sequencer.sv
// Control FSM sequencing a counter_core: start/stop/resume, preload,
// programmable terminal count and one-shot / auto-reload operation.
// Optional feature macro: COUNTER_SEQ_PRESCALE_EN (adds the prescale port;
// an advance step then happens once every prescale+1 RUN cycles).
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        start (IDLE), resume (PAUSE), restart (DONE)
//   stop         pause (RUN), abort and clear (PAUSE/DONE)
//   load         preload q from load_val (IDLE/PAUSE only)
//   load_val     preload value
//   limit        terminal count, captured on start from IDLE/DONE
//   auto_reload  1: wrap to 0 at terminal and keep running, 0: one-shot
//   prescale     (macro only) advance divider
//   q            registered count
//   busy         1 while in RUN
//   done         one-cycle pulse after each terminal event
//   state        FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  auto_reload,
`ifdef COUNTER_SEQ_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    seq_state_t            state_r;
    seq_state_t            state_nxt_s;
    logic [WIDTH-1:0]      limit_r;
    logic                  done_r;
    logic                  busy_r;
    logic [PRESCALE_W-1:0] pre_r;
    logic [PRESCALE_W-1:0] prescale_s;
    logic                  step_s;
    logic                  at_limit_s;
    logic                  clr_s;
    logic                  ld_s;
    logic                  inc_s;
    logic                  lim_ld_s;
    logic                  done_nxt_s;
    logic                  pre_clr_s;
    logic                  pre_inc_s;

`ifdef COUNTER_SEQ_PRESCALE_EN
    assign prescale_s = prescale;
`else
    // A zero divider gives one advance step per RUN cycle; the prescaler
    // then reduces to a constant and is removed by synthesis.
    assign prescale_s = {PRESCALE_W{1'b0}};
`endif

    assign step_s = (pre_r == prescale_s);

    // Next-state and datapath command decode; stop > load > start.
    always_comb begin
        state_nxt_s = state_r;
        clr_s       = 1'b0;
        ld_s        = 1'b0;
        inc_s       = 1'b0;
        lim_ld_s    = 1'b0;
        done_nxt_s  = 1'b0;
        pre_clr_s   = 1'b1;
        pre_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (load) begin
                    ld_s = 1'b1;
                end else if (start) begin
                    lim_ld_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_PAUSE;
                end else if (step_s) begin
                    if (at_limit_s) begin
                        // Terminal: pulse done, then reload or finish.
                        done_nxt_s = 1'b1;
                        if (auto_reload) begin
                            clr_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        inc_s = 1'b1;
                    end
                end else begin
                    pre_clr_s = 1'b0;
                    pre_inc_s = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    clr_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (load) begin
                    ld_s = 1'b1;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                // load is not honoured here, so it cannot block a restart.
                if (stop) begin
                    clr_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    clr_s       = 1'b1;
                    lim_ld_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                clr_s       = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, frozen limit, done pulse, busy, prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            limit_r <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            pre_r   <= {PRESCALE_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            if (lim_ld_s) begin
                limit_r <= limit;
            end else begin
                limit_r <= limit_r;
            end
            if (pre_clr_s) begin
                pre_r <= {PRESCALE_W{1'b0}};
            end else if (pre_inc_s) begin
                pre_r <= pre_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end else begin
                pre_r <= pre_r;
            end
        end
    end

    counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .clear    (reset | clr_s),
        .load     (ld_s),
        .inc      (inc_s),
        .load_val (load_val),
        .limit_r  (limit_r),
        .q        (q),
        .at_limit (at_limit_s)
    );

    assign busy  = busy_r;
    assign done  = done_r;
    assign state = state_r;

endmodule
